// File: rtl/led_status_scheduler_if.sv
// Status-LED scheduler bus: display source inputs, event handshake and LED/source outputs.
interface led_status_scheduler_if;
    logic       meter_valid;
    logic [2:0] meter_level;
    logic       evt_req;
    logic [3:0] evt_pattern;
    logic       evt_ack;
    logic       err_flag;
    logic [3:0] led;
    logic [1:0] src_sel;

    modport master (
        output meter_valid, meter_level, evt_req, evt_pattern, err_flag,
        input  evt_ack, led, src_sel
    );

    modport slave (
        input  meter_valid, meter_level, evt_req, evt_pattern, err_flag,
        output evt_ack, led, src_sel
    );
endinterface

// File: rtl/led_status_scheduler.sv
// Fixed-priority multiplexer of heartbeat, level meter, one-shot event and error blink
// onto four status LEDs, timed by a millisecond prescaler.
module led_status_scheduler #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned HOLD_MS  = 500,
    parameter int unsigned BLINK_MS = 250
) (
    input logic                   clk,
    input logic                   rst_n,
    led_status_scheduler_if.slave bus
);
    localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [15:0]   HOLD_LD   = 16'(HOLD_MS);
    localparam logic [15:0]   BLINK_MAX = 16'(BLINK_MS - 1);

    localparam logic [1:0] ST_HB    = 2'd0;
    localparam logic [1:0] ST_METER = 2'd1;
    localparam logic [1:0] ST_EVENT = 2'd2;
    localparam logic [1:0] ST_ERROR = 2'd3;

    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   blink_q, blink_d;
    logic          phase_q, phase_d;
    logic [15:0]   meter_to_q, meter_to_d;
    logic [15:0]   hold_q, hold_d;
    logic [3:0]    therm_q, therm_d;
    logic [3:0]    pat_q, pat_d;
    logic [1:0]    state_q, state_d;
    logic [3:0]    led_q, led_d;
    logic          ack_q;
    logic          tick;
    logic          accept;

    assign tick   = (presc_q == PRESC_MAX);
    // A pending request simply waits while err_flag is high; no ack is issued.
    assign accept = bus.evt_req && !bus.err_flag;

    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);

        blink_d = blink_q;
        phase_d = phase_q;
        if (tick) begin
            if (blink_q == BLINK_MAX) begin
                blink_d = '0;
                phase_d = ~phase_q;
            end else begin
                blink_d = blink_q + 16'd1;
            end
        end

        meter_to_d = meter_to_q;
        if (bus.meter_valid)
            meter_to_d = HOLD_LD;
        else if (tick && meter_to_q != '0)
            meter_to_d = meter_to_q - 16'd1;

        therm_d = therm_q;
        if (bus.meter_valid) begin
            case (bus.meter_level)
                3'd0:    therm_d = 4'b0000;
                3'd1:    therm_d = 4'b0001;
                3'd2:    therm_d = 4'b0011;
                3'd3:    therm_d = 4'b0111;
                default: therm_d = 4'b1111;
            endcase
        end

        pat_d = accept ? bus.evt_pattern : pat_q;

        hold_d = hold_q;
        if (bus.err_flag)
            hold_d = '0;
        else if (accept)
            hold_d = HOLD_LD;
        else if (tick && hold_q != '0)
            hold_d = hold_q - 16'd1;

        // Decisions use next-cycle counter values so led/src_sel land one cycle after the cause.
        if (bus.err_flag)
            state_d = ST_ERROR;
        else if (accept)
            state_d = ST_EVENT;
        else if (state_q == ST_EVENT && hold_d != '0)
            state_d = ST_EVENT;
        else if (meter_to_d != '0)
            state_d = ST_METER;
        else
            state_d = ST_HB;

        case (state_d)
            ST_HB:    led_d = {3'b000, phase_d};
            ST_METER: led_d = therm_d;
            ST_EVENT: led_d = pat_d;
            default:  led_d = {4{phase_d}};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            blink_q    <= '0;
            phase_q    <= 1'b0;
            meter_to_q <= '0;
            hold_q     <= '0;
            therm_q    <= '0;
            pat_q      <= '0;
            state_q    <= ST_HB;
            led_q      <= '0;
            ack_q      <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            blink_q    <= blink_d;
            phase_q    <= phase_d;
            meter_to_q <= meter_to_d;
            hold_q     <= hold_d;
            therm_q    <= therm_d;
            pat_q      <= pat_d;
            state_q    <= state_d;
            led_q      <= led_d;
            ack_q      <= accept;
        end
    end

    assign bus.led     = led_q;
    assign bus.src_sel = state_q;
    assign bus.evt_ack = ack_q;
endmodule

// File: tb/tb_led_status_scheduler.sv
// Directed bench for led_status_scheduler with TICK_DIV=4, HOLD_MS=5, BLINK_MS=2.
// After each reset release, edge En is the n-th rising edge; ticks land on E4, E8, ...
module tb_led_status_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    led_status_scheduler_if bus();

    led_status_scheduler #(
        .TICK_DIV(4),
        .HOLD_MS (5),
        .BLINK_MS(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        bus.meter_valid = 1'b0;
        bus.meter_level = 3'd0;
        bus.evt_req     = 1'b0;
        bus.evt_pattern = 4'd0;
        bus.err_flag    = 1'b0;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        if (bus.led !== 4'b0000) begin failures++; $display("FAIL rst_led: got %b expected %b", bus.led, 4'b0000); end
        checks++;
        if (bus.src_sel !== 2'd0) begin failures++; $display("FAIL rst_src: got %0d expected %0d", bus.src_sel, 0); end
        checks++;
        if (bus.evt_ack !== 1'b0) begin failures++; $display("FAIL rst_ack: got %b expected %b", bus.evt_ack, 1'b0); end
        checks++;
        bus.meter_valid = 1'b1; bus.meter_level = 3'd7;
        step(1);
        bus.meter_valid = 1'b0;
        if (bus.led !== 4'b1111) begin failures++; $display("FAIL pre_rst_led: got %b expected %b", bus.led, 4'b1111); end
        checks++;
        rst_n = 1'b0;
        #1;
        if (bus.led !== 4'b0000) begin failures++; $display("FAIL async_rst_led: got %b expected %b", bus.led, 4'b0000); end
        checks++;
        if (bus.src_sel !== 2'd0) begin failures++; $display("FAIL async_rst_src: got %0d expected %0d", bus.src_sel, 0); end
        checks++;
        step(2);
        rst_n = 1'b1;
        step(7);
        if (bus.led !== 4'b0000) begin failures++; $display("FAIL hb_e7: got %b expected %b", bus.led, 4'b0000); end
        checks++;
        step(1);
        if (bus.led !== 4'b0001) begin failures++; $display("FAIL hb_e8: got %b expected %b", bus.led, 4'b0001); end
        checks++;
        step(7);
        if (bus.led !== 4'b0001) begin failures++; $display("FAIL hb_e15: got %b expected %b", bus.led, 4'b0001); end
        checks++;
        step(1);
        if (bus.led !== 4'b0000) begin failures++; $display("FAIL hb_e16: got %b expected %b", bus.led, 4'b0000); end
        checks++;
    endtask

    task automatic test_meter();
        do_reset();
        bus.meter_valid = 1'b1; bus.meter_level = 3'd2;
        step(1);
        if (bus.led !== 4'b0011) begin failures++; $display("FAIL meter2_led: got %b expected %b", bus.led, 4'b0011); end
        checks++;
        if (bus.src_sel !== 2'd1) begin failures++; $display("FAIL meter2_src: got %0d expected %0d", bus.src_sel, 1); end
        checks++;
        bus.meter_level = 3'd6;
        step(1);
        bus.meter_valid = 1'b0;
        if (bus.led !== 4'b1111) begin failures++; $display("FAIL meter6_led: got %b expected %b", bus.led, 4'b1111); end
        checks++;
        step(17);
        if (bus.src_sel !== 2'd1) begin failures++; $display("FAIL meter_e19_src: got %0d expected %0d", bus.src_sel, 1); end
        checks++;
        step(1);
        if (bus.src_sel !== 2'd0) begin failures++; $display("FAIL meter_timeout_src: got %0d expected %0d", bus.src_sel, 0); end
        checks++;
        if (bus.led !== 4'b0000) begin failures++; $display("FAIL meter_timeout_led: got %b expected %b", bus.led, 4'b0000); end
        checks++;
    endtask

    task automatic test_meter_tick_reload();
        do_reset();
        step(3);
        bus.meter_valid = 1'b1; bus.meter_level = 3'd1;
        step(1);
        bus.meter_valid = 1'b0;
        if (bus.led !== 4'b0001) begin failures++; $display("FAIL reload_led: got %b expected %b", bus.led, 4'b0001); end
        checks++;
        step(16);
        if (bus.src_sel !== 2'd1) begin failures++; $display("FAIL reload_e20_src: got %0d expected %0d", bus.src_sel, 1); end
        checks++;
        step(4);
        if (bus.src_sel !== 2'd0) begin failures++; $display("FAIL reload_e24_src: got %0d expected %0d", bus.src_sel, 0); end
        checks++;
    endtask

    task automatic test_event();
        do_reset();
        bus.evt_req = 1'b1; bus.evt_pattern = 4'b1010;
        step(1);
        bus.evt_req = 1'b0;
        if (bus.evt_ack !== 1'b1) begin failures++; $display("FAIL evt_ack: got %b expected %b", bus.evt_ack, 1'b1); end
        checks++;
        if (bus.src_sel !== 2'd2) begin failures++; $display("FAIL evt_src: got %0d expected %0d", bus.src_sel, 2); end
        checks++;
        if (bus.led !== 4'b1010) begin failures++; $display("FAIL evt_led: got %b expected %b", bus.led, 4'b1010); end
        checks++;
        step(1);
        if (bus.evt_ack !== 1'b0) begin failures++; $display("FAIL evt_ack_drop: got %b expected %b", bus.evt_ack, 1'b0); end
        checks++;
        step(17);
        if (bus.led !== 4'b1010) begin failures++; $display("FAIL evt_e19_led: got %b expected %b", bus.led, 4'b1010); end
        checks++;
        step(1);
        if (bus.src_sel !== 2'd0) begin failures++; $display("FAIL evt_end_src: got %0d expected %0d", bus.src_sel, 0); end
        checks++;
        if (bus.led !== 4'b0000) begin failures++; $display("FAIL evt_end_led: got %b expected %b", bus.led, 4'b0000); end
        checks++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(2);
        bus.evt_req = 1'b1; bus.evt_pattern = 4'b1010;
        step(1);
        if (bus.evt_ack !== 1'b1) begin failures++; $display("FAIL b2b_ack1: got %b expected %b", bus.evt_ack, 1'b1); end
        checks++;
        bus.evt_pattern = 4'b0110;
        step(1);
        bus.evt_req = 1'b0;
        if (bus.evt_ack !== 1'b1) begin failures++; $display("FAIL b2b_ack2: got %b expected %b", bus.evt_ack, 1'b1); end
        checks++;
        if (bus.led !== 4'b0110) begin failures++; $display("FAIL b2b_led: got %b expected %b", bus.led, 4'b0110); end
        checks++;
        step(1);
        if (bus.evt_ack !== 1'b0) begin failures++; $display("FAIL b2b_ack_drop: got %b expected %b", bus.evt_ack, 1'b0); end
        checks++;
        step(15);
        if (bus.src_sel !== 2'd2) begin failures++; $display("FAIL b2b_e20_src: got %0d expected %0d", bus.src_sel, 2); end
        checks++;
        step(4);
        if (bus.src_sel !== 2'd0) begin failures++; $display("FAIL b2b_e24_src: got %0d expected %0d", bus.src_sel, 0); end
        checks++;
        if (bus.led !== 4'b0001) begin failures++; $display("FAIL b2b_e24_led: got %b expected %b", bus.led, 4'b0001); end
        checks++;
    endtask

    task automatic test_error_preempt();
        int acks;
        do_reset();
        bus.evt_req = 1'b1; bus.evt_pattern = 4'b0101;
        step(1);
        bus.evt_req = 1'b0;
        if (bus.led !== 4'b0101) begin failures++; $display("FAIL err_pre_led: got %b expected %b", bus.led, 4'b0101); end
        checks++;
        step(1);
        bus.err_flag = 1'b1; bus.evt_req = 1'b1; bus.evt_pattern = 4'b1100;
        step(1);
        if (bus.src_sel !== 2'd3) begin failures++; $display("FAIL err_src: got %0d expected %0d", bus.src_sel, 3); end
        checks++;
        if (bus.led !== 4'b0000) begin failures++; $display("FAIL err_e3_led: got %b expected %b", bus.led, 4'b0000); end
        checks++;
        acks = (bus.evt_ack === 1'b1) ? 1 : 0;
        for (int e = 4; e <= 16; e++) begin
            step(1);
            if (bus.evt_ack === 1'b1) acks++;
            if (e == 7) begin
                if (bus.led !== 4'b0000) begin failures++; $display("FAIL err_e7_led: got %b expected %b", bus.led, 4'b0000); end
                checks++;
            end
            if (e == 8 || e == 15) begin
                if (bus.led !== 4'b1111) begin failures++; $display("FAIL err_e%0d_led: got %b expected %b", e, bus.led, 4'b1111); end
                checks++;
            end
            if (e == 16) begin
                if (bus.led !== 4'b0000) begin failures++; $display("FAIL err_e16_led: got %b expected %b", bus.led, 4'b0000); end
                checks++;
            end
        end
        if (acks != 0) begin failures++; $display("FAIL err_no_ack: got %0d acks expected %0d", acks, 0); end
        checks++;
        bus.err_flag = 1'b0;
        step(1);
        bus.evt_req = 1'b0;
        if (bus.evt_ack !== 1'b1) begin failures++; $display("FAIL err_release_ack: got %b expected %b", bus.evt_ack, 1'b1); end
        checks++;
        if (bus.src_sel !== 2'd2) begin failures++; $display("FAIL err_release_src: got %0d expected %0d", bus.src_sel, 2); end
        checks++;
        if (bus.led !== 4'b1100) begin failures++; $display("FAIL err_release_led: got %b expected %b", bus.led, 4'b1100); end
        checks++;
        step(1);
        if (bus.evt_ack !== 1'b0) begin failures++; $display("FAIL err_release_ack_drop: got %b expected %b", bus.evt_ack, 1'b0); end
        checks++;
    endtask

    task automatic test_priority_meter();
        do_reset();
        bus.evt_req = 1'b1; bus.evt_pattern = 4'b1001;
        step(1);
        bus.evt_req = 1'b0;
        step(8);
        bus.meter_valid = 1'b1; bus.meter_level = 3'd3;
        step(1);
        bus.meter_valid = 1'b0;
        if (bus.led !== 4'b1001) begin failures++; $display("FAIL prio_evt_led: got %b expected %b", bus.led, 4'b1001); end
        checks++;
        if (bus.src_sel !== 2'd2) begin failures++; $display("FAIL prio_evt_src: got %0d expected %0d", bus.src_sel, 2); end
        checks++;
        step(9);
        if (bus.led !== 4'b1001) begin failures++; $display("FAIL prio_e19_led: got %b expected %b", bus.led, 4'b1001); end
        checks++;
        step(1);
        if (bus.led !== 4'b0111) begin failures++; $display("FAIL prio_meter_led: got %b expected %b", bus.led, 4'b0111); end
        checks++;
        if (bus.src_sel !== 2'd1) begin failures++; $display("FAIL prio_meter_src: got %0d expected %0d", bus.src_sel, 1); end
        checks++;
        step(8);
        if (bus.src_sel !== 2'd0) begin failures++; $display("FAIL prio_hb_src: got %0d expected %0d", bus.src_sel, 0); end
        checks++;
    endtask

    task automatic test_err_evt_together();
        do_reset();
        bus.err_flag = 1'b1; bus.evt_req = 1'b1; bus.evt_pattern = 4'b1111;
        step(1);
        if (bus.src_sel !== 2'd3) begin failures++; $display("FAIL both_src: got %0d expected %0d", bus.src_sel, 3); end
        checks++;
        if (bus.evt_ack !== 1'b0) begin failures++; $display("FAIL both_ack: got %b expected %b", bus.evt_ack, 1'b0); end
        checks++;
        step(1);
        bus.err_flag = 1'b0; bus.evt_req = 1'b0;
        if (bus.evt_ack !== 1'b0) begin failures++; $display("FAIL both_ack2: got %b expected %b", bus.evt_ack, 1'b0); end
        checks++;
        step(1);
        if (bus.src_sel !== 2'd0) begin failures++; $display("FAIL both_exit_src: got %0d expected %0d", bus.src_sel, 0); end
        checks++;
    endtask

    initial begin
        test_reset();
        test_meter();
        test_meter_tick_reload();
        test_event();
        test_back_to_back();
        test_error_preempt();
        test_priority_meter();
        test_err_evt_together();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/led_status_scheduler.md
# led_status_scheduler

Time-multiplexes the board's four status LEDs (led[0]..led[3] = LED1..LED4) between four display sources: heartbeat, audio level meter, one-shot event patterns and an error blink. It replaces free-running counter-driven LEDs in the audio spectrum analyzer top level and sits between the spectrum/control logic and the LED pins. A fixed-priority state machine selects the active source. A millisecond prescaler provides all display timing.

## Interface
- TICK_DIV, 50000: clk cycles per 1 ms tick (50 MHz board clock).
- HOLD_MS, 500: event display time and meter activity timeout, in ticks.
- BLINK_MS, 250: blink half-period, in ticks.

- clk  in  1  system clock (E1).
- rst_n  in  1  asynchronous, active-low reset.
- meter_valid  in  1  single-cycle strobe; meter_level is valid.
- meter_level  in  3  bar height, 0..4; values 5..7 saturate to 4.
- evt_req  in  1  level request to show evt_pattern; held until acknowledged.
- evt_pattern  in  4  pattern to display; sampled on the ack cycle.
- evt_ack  out  1  one-cycle pulse; request accepted.
- err_flag  in  1  level input; error display while high.
- led  out  4  LED drive, active-high, registered.
- src_sel  out  2  active source: 0 = HB, 1 = METER, 2 = EVENT, 3 = ERROR.

## Operation
- Reset values (async, immediate):
  - led = 0000, src_sel = 0, evt_ack = 0.
  - Prescaler, blink counter, hold counter and meter timeout are all 0.
  - blink phase = 0.
  - State = HB.
- Prescaler: counts 0..TICK_DIV-1. `tick` is asserted for one cycle when the count wraps.
- Blink phase:
  - Free-running in every state.
  - Toggles after every BLINK_MS ticks.
  - Shared by the HB and ERROR states.
- Meter timeout:
  - Loaded with HOLD_MS on meter_valid.
  - Decrements on each tick while nonzero.
  - meter_valid arriving in the same cycle as tick: the reload wins.
- Meter level latch: updated on every meter_valid in any state. The thermometer code is 0→0000, 1→0001, 2→0011, 3→0111, 4..7→1111.
- Priority: ERROR > EVENT > METER > HB.
- States and transitions (next state is evaluated every cycle):
  - ERROR, whenever err_flag = 1. Entering ERROR aborts an EVENT and clears its hold counter.
  - EVENT, on request acceptance. Leaves when the hold counter reaches 0: to METER if the meter timeout is nonzero, else to HB.
  - METER, while meter timeout ≠ 0 and no higher source is active.
  - HB, otherwise.
  - Leaving ERROR (err_flag = 0) goes to METER or HB by the same timeout rule.
- Event handshake:
  - A request is accepted in any state except ERROR (including during EVENT, which restarts the display).
  - On acceptance: evt_ack = 1 for exactly one cycle, evt_pattern is latched, the hold counter is loaded with HOLD_MS, and the state becomes EVENT.
  - The hold counter decrements on tick.
  - In ERROR, evt_ack stays 0. The request remains pending and is accepted in the first cycle after err_flag falls.
  - Requesters drop evt_req the cycle after they see evt_ack. The block treats evt_req still high in the cycle after an ack as a new request.
- LED output per state:
  - HB: {000, phase}.
  - METER: thermometer code of the latched level.
  - EVENT: latched pattern.
  - ERROR: {4{phase}}.

## Timing
- Output timing: led and src_sel are registered. Both reflect a state change one cycle after the causing input is sampled.
- err_flag rising at cycle n: src_sel = 3 at n+1.
- evt_req high at cycle n (not in ERROR): evt_ack = 1 at n+1, src_sel = 2 and led = pattern at n+1.
- Event display length: HOLD_MS ticks, ±1 tick of prescaler phase.
- meter_valid at cycle n: led updates at n+1. A level change while in METER also updates at n+1.
- Reset deassertion: the first tick occurs TICK_DIV cycles later. The first phase toggle occurs after BLINK_MS ticks.
- Counter widths: prescaler is $clog2(TICK_DIV); ms counters are 16 bits. HOLD_MS and BLINK_MS are limited to 65535.

## Test plan
All scenarios use the simulation parameters TICK_DIV=4, HOLD_MS=5, BLINK_MS=2.
- Reset mid-operation: reset asserted while led=1111 in METER → led=0000 and src_sel=0 immediately. After release, led[0] toggles every 8 clk cycles and led[3:1] stay 000.
- Meter display: meter_valid with level=2 → led=0011 and src_sel=1 next cycle. Level=6 → led=1111. No further meter_valid → return to HB after 5 ticks (~20 cycles).
- Event handshake: evt_req with pattern 1010 held → one evt_ack pulse, led=1010 for 5 ticks, then HB. Holding evt_req for 2 cycles → a second ack in the following cycle and the hold restarts.
- Error preemption: during an event with pattern 0101, raise err_flag → led blinks 0000/1111 every 8 cycles and no evt_ack is issued for a pending request. Drop err_flag → the pending request is acked next cycle.
- Priority with meter: during EVENT, send meter_valid with level=3 → led stays at the pattern. After the hold expires (meter timeout still nonzero) → led=0111, src_sel=1.
- Simultaneous events: meter_valid on a tick cycle → timeout reloads to 5, not 4. err_flag and evt_req rising together → ERROR, no ack.
